// File: rtl/dlf16_sgnj_sched_if.sv
// Handshake bundle for dlf16_sgnj_sched: two issue slots in, one tagged result stream out.
interface dlf16_sgnj_sched_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [15:0]      req0_a;
    logic [15:0]      req0_b;
    logic [1:0]       req0_sel;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [15:0]      req1_a;
    logic [15:0]      req1_b;
    logic [1:0]       req1_sel;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_data;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel, req0_tag,
        output req1_valid, req1_a, req1_b, req1_sel, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_src, rsp_tag
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_sel, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_src, rsp_tag
    );
endinterface

// File: rtl/dlf16_sgnj_sched.sv
// Round-robin share of one DLFloat16 sign-manipulation unit between two requesters,
// with a one-deep registered result stage. DLF16_SGNJ_OPCNT_EN enables the saturating op counter.
module dlf16_sgnj_sched #(
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    dlf16_sgnj_sched_if.slave      bus,
    output logic                   busy,
    output logic [15:0]            op_count
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_r;
    logic [15:0]      data_r;
    logic             src_r;
    logic [TAG_W-1:0] tag_r;

    logic             can_accept_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic [15:0]      op_a_s;
    logic [15:0]      op_b_s;
    logic [1:0]       op_sel_s;
    logic [TAG_W-1:0] op_tag_s;

    // Pure sign-bit manipulation; no NaN/zero special cases.
    function automatic logic [15:0] sgnj_op(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] sel);
        logic [15:0] r;
        r = 16'h0000;
        case (sel)
            2'b00:   r = {~a[15], a[14:0]};
            2'b01:   r = {a[15], b[14:0]};
            2'b10:   r = {~a[15], b[14:0]};
            2'b11:   r = {a[15] ^ b[15], b[14:0]};
            default: r = {~a[15], a[14:0]};
        endcase
        return r;
    endfunction

    // Arbitration: a tie goes to the requester not granted last; nothing is accepted during reset.
    always_comb begin
        can_accept_s = (state_r == EMPTY) || bus.rsp_ready;
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        if (rst || !can_accept_s) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
            gnt0_s = last_r;
            gnt1_s = ~last_r;
        end else begin
            gnt0_s = bus.req0_valid;
            gnt1_s = bus.req1_valid;
        end
    end

    // Operand mux feeding the shared datapath.
    always_comb begin
        op_a_s   = bus.req0_a;
        op_b_s   = bus.req0_b;
        op_sel_s = bus.req0_sel;
        op_tag_s = bus.req0_tag;
        if (gnt1_s) begin
            op_a_s   = bus.req1_a;
            op_b_s   = bus.req1_b;
            op_sel_s = bus.req1_sel;
            op_tag_s = bus.req1_tag;
        end else begin
            op_a_s   = bus.req0_a;
            op_b_s   = bus.req0_b;
            op_sel_s = bus.req0_sel;
            op_tag_s = bus.req0_tag;
        end
    end

    // Result-register occupancy: a grant always (re)fills it, a consume without grant empties it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (gnt0_s || gnt1_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (gnt0_s || gnt1_s) begin
                    state_nxt_s = FULL;
                end else if (bus.rsp_ready) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // State, fairness pointer and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
            last_r  <= 1'b1;
            data_r  <= 16'h0000;
            src_r   <= 1'b0;
            tag_r   <= {TAG_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (gnt0_s || gnt1_s) begin
                data_r <= sgnj_op(op_a_s, op_b_s, op_sel_s);
                src_r  <= gnt1_s;
                tag_r  <= op_tag_s;
                last_r <= gnt1_s;
            end
        end
    end

    assign bus.req0_ready = gnt0_s;
    assign bus.req1_ready = gnt1_s;
    assign bus.rsp_valid  = (state_r == FULL);
    assign bus.rsp_data   = data_r;
    assign bus.rsp_src    = src_r;
    assign bus.rsp_tag    = tag_r;
    assign busy           = (state_r == FULL) || bus.req0_valid || bus.req1_valid;

`ifdef DLF16_SGNJ_OPCNT_EN
    logic [15:0] cnt_r;

    // Completed-operation counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'h0000;
        end else if ((state_r == FULL) && bus.rsp_ready && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'h0001;
        end
    end

    assign op_count = cnt_r;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dlf16_sgnj_sched.sv
// Scoreboard bench for dlf16_sgnj_sched: directed test-plan cases, then randomized traffic.
module tb_dlf16_sgnj_sched;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sel;
        logic [3:0]  tag;
    } op_t;

    typedef struct {
        logic [15:0] data;
        logic        src;
        logic [3:0]  tag;
    } res_t;

`ifdef DLF16_SGNJ_OPCNT_EN
    localparam bit OPCNT_EN = 1'b1;
`else
    localparam bit OPCNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] op_count;

    dlf16_sgnj_sched_if #(.TAG_W(4)) bus ();

    dlf16_sgnj_sched #(.TAG_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int          n_vec   = 0;
    int          n_err   = 0;
    int          rr_prob = 100;
    op_t         stim0[$];
    op_t         stim1[$];
    res_t        exp_q[$];
    logic        m_last  = 1'b1;
    logic [15:0] m_cnt   = 16'h0000;
    logic        g0      = 1'b0;
    logic        g1      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sign chosen by the operation, magnitude from in1 for invert, else from in2.
    function automatic logic [15:0] ref_op(input op_t o);
        logic s;
        case (o.sel)
            2'd0:    s = ~o.a[15];
            2'd1:    s = o.a[15];
            2'd2:    s = ~o.a[15];
            default: s = o.a[15] ^ o.b[15];
        endcase
        return {s, (o.sel == 2'd0) ? o.a[14:0] : o.b[14:0]};
    endfunction

    function automatic op_t mk(input logic [15:0] a, input logic [15:0] b,
                               input logic [1:0] sel, input logic [3:0] tag);
        op_t o;
        o.a = a; o.b = b; o.sel = sel; o.tag = tag;
        return o;
    endfunction

    function automatic op_t rnd_op();
        return mk(16'($urandom), 16'($urandom), 2'($urandom_range(3)), 4'($urandom_range(15)));
    endfunction

    // Driver: retire granted ops and present the head of each requester queue after every edge.
    always @(posedge clk) begin
        op_t tmp;
        #1;
        if (g0 && stim0.size() > 0) tmp = stim0.pop_front();
        if (g1 && stim1.size() > 0) tmp = stim1.pop_front();
        bus.req0_valid = (stim0.size() > 0);
        tmp = (stim0.size() > 0) ? stim0[0] : rnd_op();
        bus.req0_a = tmp.a; bus.req0_b = tmp.b; bus.req0_sel = tmp.sel; bus.req0_tag = tmp.tag;
        bus.req1_valid = (stim1.size() > 0);
        tmp = (stim1.size() > 0) ? stim1[0] : rnd_op();
        bus.req1_a = tmp.a; bus.req1_b = tmp.b; bus.req1_sel = tmp.sel; bus.req1_tag = tmp.tag;
        bus.rsp_ready = ($urandom_range(99) < rr_prob);
    end

    // Monitor + model: check what the DUT shows now, then predict the coming edge.
    always @(negedge clk) begin
        res_t r;
        op_t  o;
        logic acc, e0, e1, full;
        if (rst) begin
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
            chk("rst_rsp_src", 32'(bus.rsp_src), 32'd0);
            chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
            chk("rst_op_count", 32'(op_count), 32'd0);
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
            exp_q.delete();
            m_last = 1'b1;
            m_cnt  = 16'h0000;
            g0     = 1'b0;
            g1     = 1'b0;
        end else begin
            full = (exp_q.size() > 0);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(full));
            if (full) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
                chk("rsp_src", 32'(bus.rsp_src), 32'(exp_q[0].src));
                chk("rsp_tag", 32'(bus.rsp_tag), 32'(exp_q[0].tag));
            end
            chk("busy", 32'(busy), 32'(full || bus.req0_valid || bus.req1_valid));
            chk("op_count", 32'(op_count), OPCNT_EN ? 32'(m_cnt) : 32'd0);
            acc = !full || bus.rsp_ready;
            e0  = acc && bus.req0_valid && (!bus.req1_valid || m_last);
            e1  = acc && bus.req1_valid && !e0;
            chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
            if (full && bus.rsp_ready) begin
                r = exp_q.pop_front();
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (e0 || e1) begin
                o = e1 ? mk(bus.req1_a, bus.req1_b, bus.req1_sel, bus.req1_tag)
                       : mk(bus.req0_a, bus.req0_b, bus.req0_sel, bus.req0_tag);
                r.data = ref_op(o);
                r.src  = e1;
                r.tag  = o.tag;
                exp_q.push_back(r);
                m_last = e1;
            end
            g0 = e0;
            g1 = e1;
        end
    end

    task automatic wait_idle(input int limit);
        int k = 0;
        while ((stim0.size() > 0 || stim1.size() > 0 || exp_q.size() > 0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= limit) begin
            n_err++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", k);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rr_prob = 100;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Single invert op on requester 0.
        @(negedge clk);
        stim0.push_back(mk(16'h3E00, 16'h0000, 2'b00, 4'd5));
        wait_idle(20);

        // Injection variants on requester 1.
        @(negedge clk);
        stim1.push_back(mk(16'h8000, 16'h4123, 2'b01, 4'd1));
        stim1.push_back(mk(16'h8000, 16'h4123, 2'b10, 4'd2));
        stim1.push_back(mk(16'h8000, 16'h4123, 2'b11, 4'd3));
        wait_idle(20);

        // Tie fairness with continuous demand.
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            stim0.push_back(mk(16'h1000 + 16'(i), 16'hC000, 2'b01, 4'(i)));
            stim1.push_back(mk(16'h2000 + 16'(i), 16'h4001, 2'b11, 4'(8 + i)));
        end
        wait_idle(20);

        // Back-pressure while both requesters wait.
        rr_prob = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            stim0.push_back(rnd_op());
            stim1.push_back(rnd_op());
        end
        repeat (4) @(negedge clk);
        rr_prob = 100;
        wait_idle(30);

        // Reset while FULL, then a tie right after release.
        rr_prob = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            stim0.push_back(rnd_op());
            stim1.push_back(rnd_op());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        rr_prob = 100;
        wait_idle(30);

        // Randomized traffic with random consumer stalls.
        rr_prob = 70;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (stim0.size() < 3 && $urandom_range(1) == 1) stim0.push_back(rnd_op());
            if (stim1.size() < 3 && $urandom_range(1) == 1) stim1.push_back(rnd_op());
        end
        rr_prob = 100;
        wait_idle(200);

`ifdef DLF16_SGNJ_OPCNT_EN
        // Counter saturation from a preloaded near-full value.
        @(posedge clk);
        #3;
        force dut.cnt_r = 16'hFFFE;
        m_cnt = 16'hFFFE;
        @(posedge clk);
        #3;
        release dut.cnt_r;
        @(negedge clk);
        for (int i = 0; i < 3; i++) stim0.push_back(rnd_op());
        wait_idle(30);
        chk("op_count_sat", 32'(op_count), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dlf16_sgnj_sched.md
# dlf16_sgnj_sched

Round-robin scheduler that shares one DLFloat16 sign-manipulation unit (sign invert and sign injection) between two requesters. Each accepted operation is computed and registered in a one-deep result stage that has a valid/ready handshake. The block sits between the FPU issue front-end (two issue slots) and the result writeback mux. It owns arbitration, the sign datapath and result buffering, and presents a single result stream tagged with its source.

## Interface
- TAG_W, 4, width of requester transaction tag carried through unchanged
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle (valid&ready)
- req0_a  in  16  operand in1 (DLFloat16)
- req0_b  in  16  operand in2 (DLFloat16)
- req0_sel  in  2  operation select
- req0_tag  in  TAG_W  transaction tag
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, req1_tag: same as requester 0, for requester 1
- rsp_valid  out  1  result register holds a valid result
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  result
- rsp_src  out  1  requester index that issued the result
- rsp_tag  out  TAG_W  tag of that operation
- busy  out  1  rsp_valid or any req*_valid
- op_count  out  16  completed-operation counter (see Configuration)

## Operation
- Datapath, where s = sel:
  - 00: {~a[15], a[14:0]}, invert
  - 01: {a[15], b[14:0]}, sign injection
  - 10: {~a[15], b[14:0]}, inverted injection
  - 11: {a[15]^b[15], b[14:0]}, xor injection
- The datapath is pure bit manipulation. It does no NaN/zero special-casing.
- FSM states:
  - EMPTY: result register empty.
  - FULL: result register holds a result.
- Accept condition: `can_accept = EMPTY | (FULL & rsp_ready)`.
- Grant rules:
  - When can_accept and exactly one reqN_valid, grant N.
  - When both are valid, grant the requester not granted last. Track this with a 1-bit pointer `last`.
- At most one reqN_ready is high per cycle. ready is combinational from valid, state and rsp_ready. A requester must not drop valid before ready.
- On a grant, capture data, src and tag into the result register, set `last`=N and go to FULL.
- Transitions:
  - FULL with rsp_ready and no grant: go to EMPTY.
  - FULL with rsp_ready and a grant: stay FULL with the new result (back-to-back).
  - FULL without rsp_ready: hold all result outputs stable.
- Back-pressure: while FULL and !rsp_ready, both reqN_ready = 0.

## Timing
- Latency is 1 cycle: an operation accepted at edge k is visible on rsp_* after edge k.
- Throughput is 1 op/cycle while rsp_ready is held high.
- Reset values: state EMPTY, rsp_valid 0, rsp_data 0, rsp_src 0, rsp_tag 0, last 1 (so requester 0 wins the first tie), op_count 0.
- Reset asserted mid-operation discards the held result immediately, asynchronously. Any operation presented in the reset cycle is not accepted.
- Simultaneous consume plus grant: the old result retires and the new one loads on the same edge; no bubble.
- Tie fairness: with both requesters valid continuously and rsp_ready=1, grants alternate 0,1,0,1...

## Configuration
- Macro: DLF16_SGNJ_OPCNT_EN.
- Defined:
  - op_count increments on each rsp_valid&rsp_ready edge.
  - It saturates at 16'hFFFF, with no wrap.
  - Reset clears it.
- Undefined: op_count is tied to 16'h0000 and no counter flops are generated.

## Test plan
- Reset then a single op: req0 a=16'h3E00, sel=00, tag=5 -> one cycle later rsp_valid=1, rsp_data=16'hBE00, rsp_src=0, rsp_tag=5.
- Injection ops via req1, each with a=16'h8000, b=16'h4123:
  - sel=01 -> rsp_data=16'hC123, rsp_src=1
  - sel=10 -> rsp_data=16'h4123
  - sel=11 -> rsp_data=16'hC123
- Tie fairness: both requesters valid for 4 ops, rsp_ready=1 -> grant order 0,1,0,1; 4 results on consecutive cycles; op_count=4 with macro, 0 without.
- Back-pressure: rsp_ready=0 for 3 cycles with both requesters valid -> rsp_data stable, req0_ready=req1_ready=0. When rsp_ready rises, the same cycle both retires the result and grants the next operation.
- Reset mid-stream: assert rst while FULL -> rsp_valid=0 immediately; after release, the first tie is granted to requester 0.
- Saturation (macro defined): force the counter to 16'hFFFE, complete 3 ops -> op_count=16'hFFFF.
